timebase_sched: RTL and testbench

//  Free-running WIDTH-bit system timebase with gated counting, synchronous clear,

---
 rtl/timebase_sched.sv | 131 +++++++++++++
 tb/tb_timebase_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_sched.sv
// Free-running system timebase with gated counting, tap strobes, a snapshot port
// and compare/alarm channels (one-shot or periodic) for scheduling logic.
module timebase_sched #(
  parameter int                  WIDTH        = 32,
  parameter int                  NTAPS        = 6,
  parameter int                  TAP_EXPLICIT = 0,
  parameter logic [NTAPS*8-1:0]  TAP_LIST     = '0,
  parameter int                  TAP_RISING   = 0,
  parameter int                  NALARM       = 2,
  localparam int                 IDXW         = (NALARM > 1) ? $clog2(NALARM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              snap_req,
  input  logic              alarm_wr,
  input  logic              alarm_disarm,
  input  logic [IDXW-1:0]   alarm_idx,
  input  logic [WIDTH-1:0]  alarm_target,
  input  logic [WIDTH-1:0]  alarm_period,
  output logic [WIDTH-1:0]  ticks,
  output logic [NTAPS-1:0]  taps,
  output logic [WIDTH-1:0]  snap_ticks,
  output logic              snap_valid,
  output logic [NALARM-1:0] alarm_fire,
  output logic [NALARM-1:0] alarm_armed
);

  logic [NTAPS-1:0]  tap_bit;
  logic [NTAPS-1:0]  tap_prev;
  logic [NTAPS-1:0]  tap_edge;
  logic [WIDTH-1:0]  target_q [NALARM];
  logic [WIDTH-1:0]  period_q [NALARM];
  logic [NALARM-1:0] wr_sel;
  logic [NALARM-1:0] dis_sel;
  logic [NALARM-1:0] match;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks <= '0;
    end else if (clr) begin
      ticks <= '0;
    end else if (en) begin
      ticks <= ticks + WIDTH'(1);
    end
  end

  // Tap bit positions are either spread evenly across the counter or listed explicitly.
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    localparam int BIT = (TAP_EXPLICIT != 0) ? int'(TAP_LIST[8*k +: 8])
                                             : (k * (WIDTH - 1)) / (NTAPS - 1);
    assign tap_bit[k] = ticks[BIT];
  end

  assign tap_edge = (TAP_RISING != 0) ? (tap_bit & ~tap_prev) : (tap_bit ^ tap_prev);

  // Clearing prev alongside ticks keeps the first post-clear compare at 0 vs 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_prev <= '0;
      taps     <= '0;
    end else if (clr) begin
      tap_prev <= '0;
      taps     <= '0;
    end else begin
      tap_prev <= tap_bit;
      taps     <= tap_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ticks <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_ticks <= ticks;
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    wr_sel  = '0;
    dis_sel = '0;
    match   = '0;
    for (int i = 0; i < NALARM; i++) begin
      wr_sel[i]  = alarm_wr && (alarm_idx == IDXW'(i));
      dis_sel[i] = alarm_disarm && !alarm_wr && (alarm_idx == IDXW'(i));
      match[i]   = alarm_armed[i] && (ticks == target_q[i]);
    end
  end

  // NOTE: the small per-channel target/period arrays are reset too, so a channel
  // never starts from unknown state; large RAM-style storage would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NALARM; i++) begin
        target_q[i] <= '0;
        period_q[i] <= '0;
      end
      alarm_armed <= '0;
      alarm_fire  <= '0;
    end else begin
      for (int i = 0; i < NALARM; i++) begin
        alarm_fire[i] <= 1'b0;
        // A write or disarm landing in a match cycle suppresses that fire.
        if (wr_sel[i]) begin
          target_q[i]    <= alarm_target;
          period_q[i]    <= alarm_period;
          alarm_armed[i] <= 1'b1;
        end else if (dis_sel[i]) begin
          alarm_armed[i] <= 1'b0;
        end else if (match[i]) begin
          alarm_fire[i] <= 1'b1;
          if (period_q[i] == '0) begin
            alarm_armed[i] <= 1'b0;
          end else begin
            target_q[i] <= target_q[i] + period_q[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timebase_sched.sv
// Directed bench for timebase_sched (WIDTH=8, NTAPS=4, NALARM=2); a second instance
// with rising-edge taps shares all inputs.
module tb_timebase_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       snap_req;
  logic       alarm_wr;
  logic       alarm_disarm;
  logic [0:0] alarm_idx;
  logic [7:0] alarm_target;
  logic [7:0] alarm_period;

  logic [7:0] ticks, snap_ticks;
  logic [3:0] taps;
  logic       snap_valid;
  logic [1:0] alarm_fire, alarm_armed;

  logic [7:0] ticks_r, snap_ticks_r;
  logic [3:0] taps_r;
  logic       snap_valid_r;
  logic [1:0] alarm_fire_r, alarm_armed_r;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_ticks;
  logic       wrapped;

  timebase_sched #(.WIDTH(8), .NTAPS(4), .TAP_RISING(0), .NALARM(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .snap_req(snap_req),
    .alarm_wr(alarm_wr), .alarm_disarm(alarm_disarm), .alarm_idx(alarm_idx),
    .alarm_target(alarm_target), .alarm_period(alarm_period),
    .ticks(ticks), .taps(taps), .snap_ticks(snap_ticks), .snap_valid(snap_valid),
    .alarm_fire(alarm_fire), .alarm_armed(alarm_armed)
  );

  timebase_sched #(.WIDTH(8), .NTAPS(4), .TAP_RISING(1), .NALARM(2)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .snap_req(snap_req),
    .alarm_wr(alarm_wr), .alarm_disarm(alarm_disarm), .alarm_idx(alarm_idx),
    .alarm_target(alarm_target), .alarm_period(alarm_period),
    .ticks(ticks_r), .taps(taps_r), .snap_ticks(snap_ticks_r), .snap_valid(snap_valid_r),
    .alarm_fire(alarm_fire_r), .alarm_armed(alarm_armed_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Free-running stretch: ticks increments, only the tap-3 edges may pulse, no alarm fires.
  task automatic run_to(input logic [7:0] tgt);
    while (exp_ticks != tgt) begin
      step();
      if (exp_ticks == 8'hFF) wrapped = 1'b1;
      exp_ticks++;
      check("ticks", 32'(ticks), 32'(exp_ticks));
      check("ticks_r", 32'(ticks_r), 32'(exp_ticks));
      check("tap3", 32'(taps[3]), 32'((exp_ticks == 8'h81) || (wrapped && exp_ticks == 8'h01)));
      check("tap3_rise", 32'(taps_r[3]), 32'(exp_ticks == 8'h81));
      check("fire_idle", 32'(alarm_fire), 32'(0));
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    exp_ticks    = 8'h00;
    wrapped      = 1'b0;
    rst_n        = 1'b1;
    en           = 1'b0;
    clr          = 1'b0;
    snap_req     = 1'b0;
    alarm_wr     = 1'b0;
    alarm_disarm = 1'b0;
    alarm_idx    = 1'b0;
    alarm_target = 8'h00;
    alarm_period = 8'h00;
    #1 rst_n = 1'b0;
    step();
    step();

    check("rst_ticks", 32'(ticks), 32'(0));
    check("rst_taps", 32'(taps), 32'(0));
    check("rst_snap_ticks", 32'(snap_ticks), 32'(0));
    check("rst_snap_valid", 32'(snap_valid), 32'(0));
    check("rst_fire", 32'(alarm_fire), 32'(0));
    check("rst_armed", 32'(alarm_armed), 32'(0));
    check("rst_r_all", 32'({ticks_r, taps_r, snap_ticks_r, snap_valid_r, alarm_fire_r, alarm_armed_r}), 32'(0));

    rst_n = 1'b1;
    en    = 1'b1;
    step(); exp_ticks = 8'h01;
    check("count_1", 32'(ticks), 32'(8'h01));
    check("taps_at_1", 32'(taps), 32'(4'b0000));
    step(); exp_ticks = 8'h02;
    check("count_2", 32'(ticks), 32'(8'h02));
    check("taps_at_2", 32'(taps), 32'(4'b0001));
    check("taps_r_at_2", 32'(taps_r), 32'(4'b0001));
    step(); exp_ticks = 8'h03;
    check("taps_at_3", 32'(taps), 32'(4'b0001));
    check("taps_r_at_3", 32'(taps_r), 32'(4'b0000));
    run_to(8'h05);
    check("taps_at_5", 32'(taps), 32'(4'b0011));
    check("taps_r_at_5", 32'(taps_r), 32'(4'b0010));

    // One-shot alarm 0 at 0x10, written at ticks 0x05.
    alarm_wr = 1'b1; alarm_idx = 1'b0; alarm_target = 8'h10; alarm_period = 8'h00;
    step(); exp_ticks = 8'h06;
    alarm_wr = 1'b0;
    check("a0_armed", 32'(alarm_armed), 32'(2'b01));
    run_to(8'h10);
    step(); exp_ticks = 8'h11;
    check("a0_fire", 32'(alarm_fire), 32'(2'b01));
    check("a0_disarmed", 32'(alarm_armed), 32'(2'b00));

    // Periodic alarm 1: target 0xF0, period 0x20.
    run_to(8'h20);
    alarm_wr = 1'b1; alarm_idx = 1'b1; alarm_target = 8'hF0; alarm_period = 8'h20;
    step(); exp_ticks = 8'h21;
    alarm_wr = 1'b0;
    check("a1_armed", 32'(alarm_armed), 32'(2'b10));

    // Snapshot while the counter pauses for one cycle.
    run_to(8'h42);
    snap_req = 1'b1; en = 1'b0;
    step();
    check("hold_ticks", 32'(ticks), 32'(8'h42));
    check("snap_valid", 32'(snap_valid), 32'(1));
    check("snap_ticks", 32'(snap_ticks), 32'(8'h42));
    snap_req = 1'b0; en = 1'b1;
    step(); exp_ticks = 8'h43;
    check("resume_ticks", 32'(ticks), 32'(8'h43));
    check("snap_valid_low", 32'(snap_valid), 32'(0));
    check("snap_ticks_kept", 32'(snap_ticks), 32'(8'h42));
    check("taps_after_hold", 32'(taps), 32'(4'b0000));
    step(); exp_ticks = 8'h44;
    check("taps_at_44", 32'(taps), 32'(4'b0001));

    // Back-to-back snapshots.
    run_to(8'h50);
    snap_req = 1'b1;
    step(); exp_ticks = 8'h51;
    check("b2b_snap0", 32'({snap_valid, snap_ticks}), 32'({1'b1, 8'h50}));
    step(); exp_ticks = 8'h52;
    snap_req = 1'b0;
    check("b2b_snap1", 32'({snap_valid, snap_ticks}), 32'({1'b1, 8'h51}));
    step(); exp_ticks = 8'h53;
    check("b2b_end", 32'(snap_valid), 32'(0));

    // Clear at 0x9C: no spurious strobe, alarms stay armed.
    run_to(8'h9C);
    clr = 1'b1;
    step(); exp_ticks = 8'h00;
    clr = 1'b0;
    check("clr_ticks", 32'(ticks), 32'(0));
    check("clr_taps", 32'(taps), 32'(0));
    check("clr_taps_r", 32'(taps_r), 32'(0));
    check("clr_armed", 32'(alarm_armed), 32'(2'b10));
    step(); exp_ticks = 8'h01;
    check("post_clr_ticks", 32'(ticks), 32'(8'h01));
    check("post_clr_taps", 32'(taps), 32'(0));
    step(); exp_ticks = 8'h02;
    check("post_clr_taps2", 32'(taps), 32'(4'b0001));

    // Alarm 1 fires at F1, then wraps to 11 and 31; alarm 0 stays quiet.
    run_to(8'hF0);
    step(); exp_ticks = 8'hF1;
    check("a1_fire_f1", 32'(alarm_fire), 32'(2'b10));
    check("a1_still_armed", 32'(alarm_armed), 32'(2'b10));
    run_to(8'h10);
    step(); exp_ticks = 8'h11;
    check("a1_fire_11", 32'(alarm_fire), 32'(2'b10));
    run_to(8'h30);
    step(); exp_ticks = 8'h31;
    check("a1_fire_31", 32'(alarm_fire), 32'(2'b10));
    alarm_disarm = 1'b1; alarm_idx = 1'b1;
    step(); exp_ticks = 8'h32;
    alarm_disarm = 1'b0;
    check("a1_disarmed", 32'(alarm_armed), 32'(2'b00));
    check("a1_no_fire", 32'(alarm_fire), 32'(2'b00));

    // Write landing in a match cycle wins over the fire.
    run_to(8'h52);
    alarm_wr = 1'b1; alarm_idx = 1'b0; alarm_target = 8'h60; alarm_period = 8'h00;
    step(); exp_ticks = 8'h53;
    alarm_wr = 1'b0;
    check("a0_rearmed", 32'(alarm_armed), 32'(2'b01));
    run_to(8'h60);
    alarm_wr = 1'b1; alarm_idx = 1'b0; alarm_target = 8'h70; alarm_period = 8'h00;
    step(); exp_ticks = 8'h61;
    alarm_wr = 1'b0;
    check("wr_in_match_fire", 32'(alarm_fire), 32'(2'b00));
    check("wr_in_match_armed", 32'(alarm_armed), 32'(2'b01));
    run_to(8'h70);
    step(); exp_ticks = 8'h71;
    check("a0_fire_70", 32'(alarm_fire), 32'(2'b01));
    check("a0_done_70", 32'(alarm_armed), 32'(2'b00));

    // Reset mid-operation returns everything to zero at once.
    alarm_wr = 1'b1; alarm_idx = 1'b1; alarm_target = 8'h80; alarm_period = 8'h05;
    step(); exp_ticks = 8'h72;
    alarm_wr = 1'b0;
    check("a1_armed_pre_rst", 32'(alarm_armed), 32'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ticks", 32'(ticks), 32'(0));
    check("midrst_armed", 32'(alarm_armed), 32'(0));
    check("midrst_snap", 32'(snap_ticks), 32'(0));
    check("midrst_taps", 32'(taps), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
